// File: rtl/beta_store_param.sv
// beta_store_param: layered partial-sum (beta) store for the SCAN polar decoder.
// Each layer k (1..L) is a 2^k-word register bank with a per-word written flag.
// Writes land two chunks per cycle, one in each half of the layer. Reads return
// one P-word slice, registered, with write-first forwarding.
module beta_store_param #(
  parameter int unsigned Q = 6,
  parameter int unsigned P = 32,
  parameter int unsigned N = 1024,
  localparam int unsigned L  = $clog2(N) - 2,
  localparam int unsigned CW = $clog2(N / (2 * P)) + 1,
  localparam int unsigned LW = $clog2(L + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               w_en,
  input  logic [LW-1:0]      layer_w,
  input  logic [CW-1:0]      cnta,
  input  logic [2*P*Q-1:0]   b_in,
  input  logic               r_en,
  input  logic [LW-1:0]      layer_r,
  input  logic [CW-1:0]      cntb,
  output logic [P*Q-1:0]     b_out,
  output logic               b_vld,
  output logic               b_full,
  output logic               err
);

  // Per-layer legal-access selects and gated read results.
  logic [L:1]     w_wsel;
  logic [L:1]     w_rsel;
  logic [L:1]     w_rfull_k;
  logic [P*Q-1:0] w_rdat_k [1:L];

  for (genvar k = 1; k <= L; k++) begin : g_layer
    localparam int unsigned S  = 1 << k;
    localparam int unsigned H  = S / 2;
    localparam int unsigned WC = (P < H) ? P : H;
    localparam int unsigned WN = (H > P) ? H / P : 1;
    localparam int unsigned RC = (P < S) ? P : S;
    localparam int unsigned RN = (S > P) ? S / P : 1;
    localparam logic [LW-1:0] KID  = LW'(k);
    localparam logic [CW-1:0] WN_V = CW'(WN);
    localparam logic [CW-1:0] RN_V = CW'(RN);

    logic [S*Q-1:0] r_bank;
    logic [S*Q-1:0] w_bank_nxt;
    logic [S-1:0]   r_flg;
    logic [S-1:0]   w_flg_nxt;
    logic [P*Q-1:0] w_rdat;
    logic           w_rfull;

    assign w_wsel[k] = w_en && (layer_w == KID) && (cnta < WN_V);
    assign w_rsel[k] = r_en && (layer_r == KID) && (cntb < RN_V);

    // Next bank/flag state: clear first, then apply this cycle's write.
    always_comb begin
      w_bank_nxt = r_bank;
      w_flg_nxt  = clr ? '0 : r_flg;
      if (w_wsel[k]) begin
        for (int unsigned i = 0; i < WC; i++) begin
          w_bank_nxt[(32'(cnta) * WC + i) * Q +: Q]     = b_in[i * Q +: Q];
          w_bank_nxt[(H + 32'(cnta) * WC + i) * Q +: Q] = b_in[(P + i) * Q +: Q];
          w_flg_nxt[32'(cnta) * WC + i]                 = 1'b1;
          w_flg_nxt[H + 32'(cnta) * WC + i]             = 1'b1;
        end
      end
    end

    // Read slice taken from the next state, giving write-first forwarding and
    // post-clear b_full in the same cycle.
    always_comb begin
      w_rdat  = '0;
      w_rfull = 1'b1;
      for (int unsigned i = 0; i < RC; i++) begin
        w_rdat[i * Q +: Q] = w_bank_nxt[(32'(cntb) * RC + i) * Q +: Q];
        w_rfull            = w_rfull & w_flg_nxt[32'(cntb) * RC + i];
      end
      if (!w_rsel[k]) begin
        w_rdat  = '0;
        w_rfull = 1'b0;
      end
    end

    assign w_rdat_k[k]  = w_rdat;
    assign w_rfull_k[k] = w_rfull;

    // Bank and written-flag registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_bank <= '0;
        r_flg  <= '0;
      end else begin
        r_bank <= w_bank_nxt;
        r_flg  <= w_flg_nxt;
      end
    end
  end

  logic [P*Q-1:0] w_rdat_any;
  logic           w_rfull_any;
  logic           w_rok;
  logic           w_werr;
  logic           w_rerr;

  // Merge the per-layer slices; at most one layer is selected.
  always_comb begin
    w_rdat_any  = '0;
    w_rfull_any = 1'b0;
    for (int unsigned k = 1; k <= L; k++) begin
      w_rdat_any  = w_rdat_any | w_rdat_k[k];
      w_rfull_any = w_rfull_any | w_rfull_k[k];
    end
  end

  assign w_rok  = |w_rsel;
  assign w_werr = w_en && !(|w_wsel);
  assign w_rerr = r_en && !w_rok;

  // Registered read response and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_out  <= '0;
      b_vld  <= 1'b0;
      b_full <= 1'b0;
      err    <= 1'b0;
    end else begin
      b_out  <= w_rdat_any;
      b_vld  <= w_rok;
      b_full <= w_rfull_any;
      err    <= w_werr | w_rerr;
    end
  end

endmodule

// File: tb/tb_beta_store_param.sv
// tb_beta_store_param: scoreboard bench for beta_store_param (Q=6, P=32, N=1024).
module tb_beta_store_param;
  localparam int unsigned Q  = 6;
  localparam int unsigned P  = 32;
  localparam int unsigned N  = 1024;
  localparam int unsigned L  = 8;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = 4;
  localparam int unsigned MW = N / 4;

  logic             clk;
  logic             rst, clr, w_en, r_en;
  logic [LW-1:0]    layer_w, layer_r;
  logic [CW-1:0]    cnta, cntb;
  logic [2*P*Q-1:0] b_in;
  logic [P*Q-1:0]   b_out;
  logic             b_vld, b_full, err;

  beta_store_param #(.Q(Q), .P(P), .N(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .layer_w(layer_w),
    .cnta(cnta), .b_in(b_in), .r_en(r_en), .layer_r(layer_r), .cntb(cntb),
    .b_out(b_out), .b_vld(b_vld), .b_full(b_full), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned    tgt;
    logic [P*Q-1:0] d;
    logic           v;
    logic           f;
    logic           e;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: word arrays per layer plus written flags.
  logic [Q-1:0] mem [1:L][0:MW-1];
  bit           wrf [1:L][0:MW-1];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned f_min(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned f_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  task automatic drive(input logic i_rst, input logic i_clr, input logic i_wen,
                       input int unsigned lw, input int unsigned ca,
                       input logic [2*P*Q-1:0] bin, input logic i_ren,
                       input int unsigned lr, input int unsigned cb);
    exp_t        e;
    bit          wl, rl;
    int unsigned h, s, wc, rc;
    @(negedge clk);
    rst = i_rst; clr = i_clr; w_en = i_wen; r_en = i_ren;
    layer_w = LW'(lw); cnta = CW'(ca); b_in = bin;
    layer_r = LW'(lr); cntb = CW'(cb);
    e.tgt = cyc + 1; e.d = '0; e.v = 1'b0; e.f = 1'b0; e.e = 1'b0;
    if (!i_rst) begin
      for (int k = 1; k <= int'(L); k++)
        for (int j = 0; j < int'(MW); j++) begin
          mem[k][j] = '0;
          wrf[k][j] = 1'b0;
        end
    end else begin
      wl = i_wen && lw >= 1 && lw <= L && ca < f_max(1, (1 << (lw - 1)) / P);
      rl = i_ren && lr >= 1 && lr <= L && cb < f_max(1, (1 << lr) / P);
      if (i_clr)
        for (int k = 1; k <= int'(L); k++)
          for (int j = 0; j < int'(MW); j++) wrf[k][j] = 1'b0;
      if (wl) begin
        h  = 1 << (lw - 1);
        wc = f_min(P, h);
        for (int unsigned i = 0; i < wc; i++) begin
          mem[lw][ca * wc + i]     = bin[i * Q +: Q];
          mem[lw][h + ca * wc + i] = bin[(P + i) * Q +: Q];
          wrf[lw][ca * wc + i]     = 1'b1;
          wrf[lw][h + ca * wc + i] = 1'b1;
        end
      end
      if (rl) begin
        s   = 1 << lr;
        rc  = f_min(P, s);
        e.v = 1'b1;
        e.f = 1'b1;
        for (int unsigned i = 0; i < rc; i++) begin
          e.d[i * Q +: Q] = mem[lr][cb * rc + i];
          e.f = e.f & wrf[lr][cb * rc + i];
        end
      end
      e.e = (i_wen && !wl) || (i_ren && !rl);
    end
    q.push_back(e);
  endtask

  task automatic wr(input int unsigned lw, input int unsigned ca, input logic [2*P*Q-1:0] bin);
    drive(1'b1, 1'b0, 1'b1, lw, ca, bin, 1'b0, 0, 0);
  endtask

  task automatic rd(input int unsigned lr, input int unsigned cb);
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b1, lr, cb);
  endtask

  // Monitor: compare DUT outputs with every expectation due this cycle.
  exp_t me;
  always @(posedge clk) begin
    #1;
    while (q.size() != 0 && q[0].tgt <= cyc) begin
      me = q.pop_front();
      n_cmp++;
      if (me.tgt != cyc) begin
        n_bad++;
        $display("FAIL stale_expect: due cycle %0d, now cycle %0d", me.tgt, cyc);
      end else if (b_out !== me.d || b_vld !== me.v || b_full !== me.f || err !== me.e) begin
        n_bad++;
        $display("FAIL resp cyc%0d: got vld=%b full=%b err=%b out=%h ; want vld=%b full=%b err=%b out=%h",
                 cyc, b_vld, b_full, err, b_out, me.v, me.f, me.e, me.d);
      end
    end
  end

  logic [2*P*Q-1:0] bv;
  int unsigned      lw, ca, lr, cb;

  initial begin
    rst = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
    layer_w = '0; layer_r = '0; cnta = '0; cntb = '0; b_in = '0;

    // Reset, then read an empty layer.
    drive(1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0);
    rd(8, 0);

    // Layer 8 fill and readback.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < P; i++) begin
        bv[i * Q +: Q]       = Q'((c * 32 + i) % 64);
        bv[(P + i) * Q +: Q] = Q'(((c * 32 + i) % 64) ^ 63);
      end
      wr(8, c, bv);
    end
    for (int unsigned c = 0; c < 8; c++) rd(8, c);

    // Small layers.
    bv = '0;
    bv[0 * Q +: Q] = Q'(5); bv[1 * Q +: Q] = Q'(6);
    bv[P * Q +: Q] = Q'(7); bv[(P + 1) * Q +: Q] = Q'(8);
    wr(2, 0, bv);
    rd(2, 0);
    rd(1, 0);

    // Forwarding on layer 6.
    for (int unsigned i = 0; i < 2 * P; i++) bv[i * Q +: Q] = Q'(1);
    wr(6, 0, bv);
    rd(6, 1);
    for (int unsigned i = 0; i < 2 * P; i++) bv[i * Q +: Q] = Q'(9);
    drive(1'b1, 1'b0, 1'b1, 6, 0, bv, 1'b1, 6, 0);
    rd(6, 1);

    // clr with a simultaneous layer-8 write.
    for (int unsigned i = 0; i < 2 * P; i++) bv[i * Q +: Q] = Q'(i ^ 21);
    drive(1'b1, 1'b1, 1'b1, 8, 2, bv, 1'b0, 0, 0);
    rd(8, 2);
    rd(8, 0);
    rd(8, 6);

    // Illegal accesses.
    for (int unsigned i = 0; i < 2 * P; i++) bv[i * Q +: Q] = Q'(63);
    wr(8, 4, bv);
    rd(8, 4);
    rd(5, 1);
    wr(0, 0, bv);
    rd(0, 0);
    rd(9, 0);
    drive(1'b1, 1'b0, 1'b1, 3, 1, bv, 1'b1, 3, 1);
    rd(2, 0);

    // Reset in the middle of a write burst.
    wr(8, 0, bv);
    drive(1'b0, 1'b0, 1'b1, 8, 1, bv, 1'b1, 8, 0);
    wr(8, 2, bv);
    rd(8, 0);
    rd(8, 2);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int unsigned i = 0; i < 2 * P; i++) bv[i * Q +: Q] = Q'($urandom);
      lw = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : $urandom_range(1, L);
      lr = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : $urandom_range(1, L);
      ca = (lw >= 1 && lw <= L) ? $urandom_range(0, f_max(1, (1 << (lw - 1)) / P) - 1) : 0;
      cb = (lr >= 1 && lr <= L) ? $urandom_range(0, f_max(1, (1 << lr) / P) - 1) : 0;
      if ($urandom_range(0, 19) == 0) ca = $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) cb = $urandom_range(0, 31);
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) != 0), lw, ca, bv,
            ($urandom_range(0, 2) != 0), lr, cb);
    end

    drive(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/beta_store_param.md
# beta_store_param

Parametrised partial-sum (beta) store for the SCAN polar decoder. It holds the hard/soft beta vectors of every intermediate layer for code length N and processing parallelism P, and accepts 2P-word write bursts from the combine stage. It returns P-word read slices to the processing-element array. Compared with the fixed 1024/32 store, it adds:
- generic N/P/Q,
- per-chunk written tracking with a codeword clear,
- same-cycle write-to-read forwarding,
- out-of-range error flagging,
- a registered read-valid handshake.

## Interface
Parameters:
- Q, 6, bits per beta word
- P, 32, words per read slice; power of two, 2 ≤ P ≤ N/8
- N, 1024, code length; power of two
- L, $clog2(N)-2 (derived, localparam), highest stored layer
- CW, $clog2(N/(2*P))+1 (derived, localparam), width of the chunk counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- clr  in  1  codeword clear; drops all written flags; storage contents are kept
- w_en  in  1  write strobe
- layer_w  in  $clog2(L+1)  write layer, 1..L
- cnta  in  CW  write chunk index
- b_in  in  2*P*Q  write data; low half [P*Q-1:0], high half [2*P*Q-1:P*Q]
- r_en  in  1  read strobe
- layer_r  in  $clog2(L+1)  read layer, 1..L
- cntb  in  CW  read chunk index
- b_out  out  P*Q  read slice; word i at [(i+1)*Q-1 -: Q]
- b_vld  out  1  b_out holds a legal read
- b_full  out  1  every word of the slice was written since the last clr or reset
- err  out  1  one-cycle pulse: illegal layer or chunk index on the previous cycle's w_en or r_en

## Operation
Storage layout:
- Layer k (1..L) holds S_k = 2^k words, split into halves H_k = 2^(k-1).
- Word j of layer k is at bit offset j*Q of that layer's bank.

Write (w_en=1, layer_w=k):
- Chunk size: WC_k = min(P, H_k). Legal chunk count: WN_k = max(1, H_k/P).
- The low WC_k words of b_in's low half go to words cnta*WC_k .. +WC_k-1.
- The low WC_k words of b_in's high half go to words H_k + cnta*WC_k .. +WC_k-1.
- Unused b_in words are ignored.
- The written flags of both target ranges are set.

Read (r_en=1, layer_r=k):
- Chunk size: RC_k = min(P, S_k). Legal chunk count: RN_k = max(1, S_k/P).
- b_out words 0..RC_k-1 are taken from layer words cntb*RC_k ..; words RC_k..P-1 are 0.
- b_full is the AND of the written flags over those RC_k words.

Illegal access:
- Illegal when the layer is 0 or > L, or cnta ≥ WN_k (write) / cntb ≥ RN_k (read).
- An illegal write changes nothing.
- An illegal read gives b_out=0, b_vld=0, b_full=0.
- Either case asserts err.

Forwarding:
- If a legal write and a legal read on the same layer overlap in the same cycle, the read returns the newly written words, i.e. write-first semantics.

clr:
- clr=1 clears every written flag.
- If w_en is also high that cycle, the flags of that write are then set (write wins).
- A read in the clr cycle returns b_full computed after the clear and the write.

Reset (rst=0):
- All storage, all flags, b_out, b_vld, b_full and err go to 0.
- w_en, r_en and clr are ignored during reset.
- A reset asserted mid-burst discards the burst with no partial retention.

## Timing
- Read latency is 1 cycle: b_out, b_vld and b_full are registered and update on the edge after the r_en cycle.
- With r_en=0, the next cycle gives b_out=0, b_vld=0, b_full=0.
- Write takes effect on the edge; a read issued the following cycle sees it.
- err is registered and asserts on the edge after the offending cycle, for one cycle per offending cycle.
- Back-to-back reads and writes every cycle are supported; there is no stall and no ready signal.

## Test plan
Defaults Q=6, P=32, N=1024 (L=8).
- **Reset:** drive rst=0 for 2 cycles, then r_en on layer 8, cntb=0 → b_out=0, b_vld=1, b_full=0, err=0.
- **Layer 8:**
  - Write cnta=0..3, with the low half word i = (cnta*32+i) mod 64 and the high half = that value XOR 63.
  - Read cntb=0..7 → slices 0..3 return the low pattern and slices 4..7 the XOR pattern; b_full=1 on each.
- **Small layers:**
  - Write layer 2 with b_in low half words 0..1 = 5,6 and high half words 0..1 = 7,8.
  - Read layer 2 → b_out words 0..3 = 5,6,7,8, words 4..31 = 0, b_full=1.
  - Read layer 1 while it is unwritten → b_full=0.
- **Forwarding:**
  - Layer 6 holds all 1.
  - In the same cycle, write cnta=0 with all words = 9 and read cntb=0.
  - → b_out all 9 the next cycle.
- **clr:**
  - After the layer-8 fill, pulse clr with a simultaneous write of layer 8 cnta=2.
  - Read cntb=2 → b_full=1. Read cntb=0 → b_full=0, data unchanged.
- **Errors:**
  - Write layer 8 with cnta=4 → err=1 for one cycle, storage unchanged.
  - Read layer 5 with cntb=1 → err=1, b_vld=0, b_out=0.
  - Use layer_w=0 → err=1.
  - Assert rst=0 mid-burst → all outputs 0 the next cycle.
